// File: rtl/led_pattern_seq_pkg.sv
// rtl/led_pattern_seq_pkg.sv - shared types and helpers for the LED pattern sequencer
package led_pkg;

    typedef enum logic [1:0] {
        MODE_STOP    = 2'd0,
        MODE_LOOP    = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    // Brightness code meaning "always on" for a w-bit level.
    function automatic int unsigned pwm_full(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/led_pattern_seq_if.sv
// rtl/led_pattern_seq_if.sv - configuration valid/ready port of the LED pattern sequencer
interface led_pattern_seq_if #(
    parameter int NUM_CH  = 4,
    parameter int PAT_LEN = 32,
    parameter int DIV_W   = 24,
    parameter int PWM_W   = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic               cfg_valid;
    logic               cfg_ready;
    logic [CH_W-1:0]    cfg_ch;
    logic [1:0]         cfg_mode;
    logic [PAT_LEN-1:0] cfg_pattern;
    logic [DIV_W-1:0]   cfg_period;
    logic [PWM_W-1:0]   cfg_level;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_pattern, cfg_period, cfg_level,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_pattern, cfg_period, cfg_level,
        output cfg_ready
    );
endinterface

// File: rtl/led_pattern_seq_channel.sv
// rtl/led_pattern_seq_channel.sv - one LED channel: pattern replay FSM with step divider and PWM gate
module led_channel
    import led_pkg::*;
#(
    parameter int PAT_LEN = 32,
    parameter int DIV_W   = 24,
    parameter int PWM_W   = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               load_i,
    input  logic [1:0]         mode_i,
    input  logic [PAT_LEN-1:0] pattern_i,
    input  logic [DIV_W-1:0]   period_i,
    input  logic [PWM_W-1:0]   level_i,
    input  logic [PWM_W-1:0]   pwm_cnt_i,
    output logic               led_o,
    output logic               busy_o,
    output logic               done_o
);
    localparam int IDX_W = $clog2(PAT_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_LEN - 1);
    localparam logic [PWM_W-1:0] LVL_FULL = PWM_W'(pwm_full(PWM_W));

    ch_state_e          state_q;
    mode_e              mode_q;
    logic [PAT_LEN-1:0] pat_q;
    logic [DIV_W-1:0]   per_q;
    logic [DIV_W-1:0]   div_q;
    logic [IDX_W-1:0]   idx_q;
    logic [PWM_W-1:0]   lvl_q;
    logic               done_q;
    logic               start;
    logic               pwm_on;

    assign start = (mode_i == MODE_LOOP) || (mode_i == MODE_ONESHOT);

    // A config load always takes priority over stepping or completion.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_STOP;
            pat_q   <= '0;
            per_q   <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            lvl_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load_i) begin
                if (start) begin
                    state_q <= ST_RUN;
                    mode_q  <= mode_e'(mode_i);
                    pat_q   <= pattern_i;
                    per_q   <= period_i;
                    lvl_q   <= level_i;
                    div_q   <= '0;
                    idx_q   <= '0;
                end else begin
                    state_q <= ST_IDLE;
                end
            end else if (state_q == ST_RUN) begin
                if (div_q == per_q) begin
                    div_q <= '0;
                    if (idx_q == IDX_LAST) begin
                        if (mode_q == MODE_ONESHOT) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= '0;
                        end
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end else begin
                    div_q <= div_q + DIV_W'(1);
                end
            end
        end
    end

    assign pwm_on = (lvl_q == LVL_FULL) || (pwm_cnt_i < lvl_q);
    assign led_o  = (state_q == ST_RUN) && pat_q[idx_q] && pwm_on;
    assign busy_o = (state_q == ST_RUN);
    assign done_o = done_q;

endmodule

// File: rtl/led_pattern_seq.sv
// rtl/led_pattern_seq.sv - multi-channel LED pattern sequencer top: PWM timebase, channel decode, channels
module led_pattern_seq
    import led_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int PAT_LEN = 32,
    parameter int DIV_W   = 24,
    parameter int PWM_W   = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    led_pattern_seq_if.slave  cfg,
    output logic [NUM_CH-1:0] led_o,
    output logic [NUM_CH-1:0] busy_o,
    output logic [NUM_CH-1:0] done_o,
    output logic              usbpu_o
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PWM_W-1:0]  pwm_q;
    logic [PWM_W-1:0]  pwm_d;
    logic              accept;
    logic [NUM_CH-1:0] load;

    assign cfg.cfg_ready = rst_n_i;
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign usbpu_o       = 1'b0;
    assign pwm_d         = pwm_q + PWM_W'(1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    // Out-of-range channel numbers match no strobe and are silently dropped.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign load[c] = accept && (cfg.cfg_ch == CH_W'(c));

        led_channel #(
            .PAT_LEN (PAT_LEN),
            .DIV_W   (DIV_W),
            .PWM_W   (PWM_W)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_n_i   (rst_n_i),
            .load_i    (load[c]),
            .mode_i    (cfg.cfg_mode),
            .pattern_i (cfg.cfg_pattern),
            .period_i  (cfg.cfg_period),
            .level_i   (cfg.cfg_level),
            .pwm_cnt_i (pwm_q),
            .led_o     (led_o[c]),
            .busy_o    (busy_o[c]),
            .done_o    (done_o[c])
        );
    end

endmodule
